vga_ball_disp: RTL



---
 rtl/vga_ball_disp_if.sv | 26 ++
 rtl/vga_ball_disp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vga_ball_disp_if.sv
// Pixel-stage bus between the HV counter/sync generator and the ball renderer.
interface vga_ball_disp_if;
    logic [9:0] HCNT;
    logic [9:0] VCNT;
    logic       HS_IN;
    logic       VS_IN;
    logic       PAUSE;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       FRAME;
    logic [9:0] BALL_X;
    logic [9:0] BALL_Y;

    modport master (
        output HCNT, VCNT, HS_IN, VS_IN, PAUSE,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME, BALL_X, BALL_Y
    );

    modport slave (
        input  HCNT, VCNT, HS_IN, VS_IN, PAUSE,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, FRAME, BALL_X, BALL_Y
    );
endinterface

// File: rtl/vga_ball_disp.sv
// Bouncing-ball pixel colour stage, 2-cycle pipeline with sync realignment.
// Optional macro VGA_BORDER_EN draws a 1-pixel white frame around the visible area.
module vga_ball_disp #(
    parameter int          HDISP     = 640,
    parameter int          VDISP     = 480,
    parameter int          BALL_SIZE = 16,
    parameter int          X_STEP    = 2,
    parameter int          Y_STEP    = 1,
    parameter logic [11:0] BALL_RGB  = 12'hF00,
    parameter logic [11:0] BG_RGB    = 12'h00F
) (
    input  logic            CLK,
    input  logic            RST,
    vga_ball_disp_if.slave  bus
);
    typedef enum logic [1:0] {L_U = 2'b00, L_D = 2'b01, R_U = 2'b10, R_D = 2'b11} dir_t;

    dir_t        dir;
    logic [9:0]  ball_x, ball_y;
    logic        frame_q;
    logic        disp_s1, hit_s1, border_s1, hs_s1, vs_s1;
    logic [11:0] rgb_q;
    logic        hs_q, vs_q;

    // 11-bit differences: a pixel left of/above the ball wraps to >=1024 and misses
    logic [10:0] hdiff, vdiff;
    logic        disp_c, hit_c, border_c, tick;

    assign hdiff  = {1'b0, bus.HCNT} - {1'b0, ball_x};
    assign vdiff  = {1'b0, bus.VCNT} - {1'b0, ball_y};
    assign disp_c = (bus.HCNT < 10'(HDISP)) && (bus.VCNT < 10'(VDISP));
    assign hit_c  = (hdiff < 11'(BALL_SIZE)) && (vdiff < 11'(BALL_SIZE));
    assign tick   = (bus.HCNT == 10'd0) && (bus.VCNT == 10'(VDISP));

`ifdef VGA_BORDER_EN
    assign border_c = (bus.HCNT == 10'd0) || (bus.HCNT == 10'(HDISP - 1)) ||
                      (bus.VCNT == 10'd0) || (bus.VCNT == 10'(VDISP - 1));
`else
    assign border_c = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            disp_s1   <= 1'b0;
            hit_s1    <= 1'b0;
            border_s1 <= 1'b0;
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
        end else begin
            disp_s1   <= disp_c;
            hit_s1    <= hit_c;
            border_s1 <= border_c;
            hs_s1     <= bus.HS_IN;
            vs_s1     <= bus.VS_IN;
        end
    end

    logic [11:0] pix;
    always_comb begin
        pix = BG_RGB;
        if (!disp_s1)       pix = 12'h000;
        else if (border_s1) pix = 12'hFFF;
        else if (hit_s1)    pix = BALL_RGB;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= pix;
            hs_q  <= hs_s1;
            vs_q  <= vs_s1;
        end
    end

    // Next position/direction per axis; clamps to the wall and reverses on overshoot
    logic [9:0] x_nxt, y_nxt;
    logic       xr_nxt, yd_nxt;
    always_comb begin
        x_nxt  = ball_x;
        xr_nxt = dir[1];
        if (dir[1]) begin
            if ({1'b0, ball_x} + 11'(BALL_SIZE + X_STEP) > 11'(HDISP)) begin
                x_nxt  = 10'(HDISP - BALL_SIZE);
                xr_nxt = 1'b0;
            end else x_nxt = ball_x + 10'(X_STEP);
        end else if (ball_x < 10'(X_STEP)) begin
            x_nxt  = 10'd0;
            xr_nxt = 1'b1;
        end else x_nxt = ball_x - 10'(X_STEP);

        y_nxt  = ball_y;
        yd_nxt = dir[0];
        if (dir[0]) begin
            if ({1'b0, ball_y} + 11'(BALL_SIZE + Y_STEP) > 11'(VDISP)) begin
                y_nxt  = 10'(VDISP - BALL_SIZE);
                yd_nxt = 1'b0;
            end else y_nxt = ball_y + 10'(Y_STEP);
        end else if (ball_y < 10'(Y_STEP)) begin
            y_nxt  = 10'd0;
            yd_nxt = 1'b1;
        end else y_nxt = ball_y - 10'(Y_STEP);
    end

    // Position moves only on the first blank line, so a frame never tears
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dir     <= R_D;
            ball_x  <= 10'd0;
            ball_y  <= 10'd0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= tick;
            if (tick && !bus.PAUSE) begin
                ball_x <= x_nxt;
                ball_y <= y_nxt;
                dir    <= dir_t'({xr_nxt, yd_nxt});
            end
        end
    end

    assign bus.VGA_R  = rgb_q[11:8];
    assign bus.VGA_G  = rgb_q[7:4];
    assign bus.VGA_B  = rgb_q[3:0];
    assign bus.VGA_HS = hs_q;
    assign bus.VGA_VS = vs_q;
    assign bus.FRAME  = frame_q;
    assign bus.BALL_X = ball_x;
    assign bus.BALL_Y = ball_y;
endmodule
